// File: rtl/mbist_resp_checker_if.sv
// Bundle of MBIST read-request, MUT read-data and verdict signals for the response checker.
// The master modport drives the test and read side; the slave modport belongs to the checker.
interface mbist_resp_checker_if #(
    parameter int DW = 8,
    parameter int AW = 8,
    parameter int CW = 8
);
    logic          test_start;
    logic          test_end;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] exp_data;
    logic [DW-1:0] cmp_mask;
    logic [DW-1:0] mut_data;
    logic          busy;
    logic          done;
    logic          pass;
    logic          fail;
    logic [CW-1:0] fail_cnt;
    logic          ff_vld;
    logic [AW-1:0] ff_addr;
    logic [DW-1:0] ff_data;
    logic [DW-1:0] ff_exp;

    modport master (
        output test_start, test_end, rd_en, rd_addr, exp_data, cmp_mask, mut_data,
        input  busy, done, pass, fail, fail_cnt, ff_vld, ff_addr, ff_data, ff_exp
    );

    modport slave (
        input  test_start, test_end, rd_en, rd_addr, exp_data, cmp_mask, mut_data,
        output busy, done, pass, fail, fail_cnt, ff_vld, ff_addr, ff_data, ff_exp
    );
endinterface

// File: rtl/mbist_resp_checker.sv
// MBIST response checker: delays each read request by RD_LAT cycles so it lines up with the
// MUT read data, does a masked compare, and keeps sticky fail, count and first-fail log.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for test_start, reads and test_end ignored
//   S_RUN   | reads accepted into the alignment pipe
//   S_DRAIN | no new reads, waits RD_LAT cycles for in-flight compares
//   S_DONE  | verdict held on done/pass until the next test_start
module mbist_resp_checker #(
    parameter int DW     = 8,
    parameter int AW     = 8,
    parameter int RD_LAT = 1,
    parameter int CW     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mbist_resp_checker_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [2:0]    r_drain_cnt;
    logic          w_start_run;
    logic          w_load_drain;
    logic          w_busy;
    logic          w_done;

    logic          r_pipe_vld  [RD_LAT];
    logic [AW-1:0] r_pipe_addr [RD_LAT];
    logic [DW-1:0] r_pipe_exp  [RD_LAT];
    logic [DW-1:0] r_pipe_mask [RD_LAT];

    logic          w_accept;
    logic          w_mism;

    logic          r_fail;
    logic [CW-1:0] r_fail_cnt;
    logic          r_ff_vld;
    logic [AW-1:0] r_ff_addr;
    logic [DW-1:0] r_ff_data;
    logic [DW-1:0] r_ff_exp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= 3'd0;
        end else begin
            r_state <= w_next;
            if (w_load_drain)
                r_drain_cnt <= 3'(RD_LAT);
            else if (r_state == S_DRAIN && r_drain_cnt != 3'd0)
                r_drain_cnt <= r_drain_cnt - 3'd1;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_start_run  = 1'b0;
        w_load_drain = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.test_start) begin
                    w_next      = S_RUN;
                    w_start_run = 1'b1;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (bus.test_end) begin
                    w_next       = S_DRAIN;
                    w_load_drain = 1'b1;
                end
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                if (r_drain_cnt == 3'd0)
                    w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                if (bus.test_start) begin
                    w_next      = S_RUN;
                    w_start_run = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // A read issued in the same cycle as test_end is still accepted (state is RUN).
    assign w_accept = (r_state == S_RUN) && bus.rd_en;

    always_ff @(posedge clk) begin
        if (rst || w_start_run) begin
            for (int i = 0; i < RD_LAT; i++)
                r_pipe_vld[i] <= 1'b0;
        end else begin
            r_pipe_vld[0] <= w_accept;
            for (int i = 1; i < RD_LAT; i++)
                r_pipe_vld[i] <= r_pipe_vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pipe_addr[0] <= bus.rd_addr;
            r_pipe_exp[0]  <= bus.exp_data;
            r_pipe_mask[0] <= bus.cmp_mask;
        end
        for (int i = 1; i < RD_LAT; i++) begin
            r_pipe_addr[i] <= r_pipe_addr[i-1];
            r_pipe_exp[i]  <= r_pipe_exp[i-1];
            r_pipe_mask[i] <= r_pipe_mask[i-1];
        end
    end

    assign w_mism = r_pipe_vld[RD_LAT-1] &&
                    (|((bus.mut_data ^ r_pipe_exp[RD_LAT-1]) & r_pipe_mask[RD_LAT-1]));

    always_ff @(posedge clk) begin
        if (rst || w_start_run) begin
            r_fail     <= 1'b0;
            r_fail_cnt <= '0;
            r_ff_vld   <= 1'b0;
            r_ff_addr  <= '0;
            r_ff_data  <= '0;
            r_ff_exp   <= '0;
        end else if (w_mism) begin
            r_fail <= 1'b1;
            if (r_fail_cnt != {CW{1'b1}})
                r_fail_cnt <= r_fail_cnt + CW'(1);
            if (!r_ff_vld) begin
                r_ff_vld  <= 1'b1;
                r_ff_addr <= r_pipe_addr[RD_LAT-1];
                r_ff_data <= bus.mut_data;
                r_ff_exp  <= r_pipe_exp[RD_LAT-1];
            end
        end
    end

    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.pass     = w_done & ~r_fail;
    assign bus.fail     = r_fail;
    assign bus.fail_cnt = r_fail_cnt;
    assign bus.ff_vld   = r_ff_vld;
    assign bus.ff_addr  = r_ff_addr;
    assign bus.ff_data  = r_ff_data;
    assign bus.ff_exp   = r_ff_exp;

endmodule

// File: tb/tb_mbist_resp_checker.sv
// Directed bench: instance A (RD_LAT=1, CW=8) covers the main checks, instance B
// (RD_LAT=3, CW=2) covers counter saturation and the read-with-test_end drain.
module tb_mbist_resp_checker;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    mbist_resp_checker_if #(.DW(8), .AW(8), .CW(8)) ifa ();
    mbist_resp_checker_if #(.DW(8), .AW(8), .CW(2)) ifb ();

    mbist_resp_checker #(.DW(8), .AW(8), .RD_LAT(1), .CW(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    mbist_resp_checker #(.DW(8), .AW(8), .RD_LAT(3), .CW(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a();
        ifa.test_start = 1'b1;
        tick();
        ifa.test_start = 1'b0;
    endtask

    task automatic end_a();
        ifa.test_end = 1'b1;
        tick();
        ifa.test_end = 1'b0;
    endtask

    // One read on A: request this cycle, MUT data in the following cycle.
    task automatic rd_a(input logic [7:0] addr, input logic [7:0] exp, input logic [7:0] mask,
                        input logic [7:0] mut);
        ifa.rd_en    = 1'b1;
        ifa.rd_addr  = addr;
        ifa.exp_data = exp;
        ifa.cmp_mask = mask;
        tick();
        ifa.rd_en    = 1'b0;
        ifa.mut_data = mut;
        tick();
    endtask

    // One read on B: MUT data arrives three cycles after the request.
    task automatic rd_b(input logic [7:0] addr, input logic [7:0] exp, input logic [7:0] mut,
                        input logic with_end);
        ifb.rd_en    = 1'b1;
        ifb.test_end = with_end;
        ifb.rd_addr  = addr;
        ifb.exp_data = exp;
        ifb.cmp_mask = 8'hFF;
        tick();
        ifb.rd_en    = 1'b0;
        ifb.test_end = 1'b0;
        tick();
        tick();
        ifb.mut_data = mut;
        tick();
        ifb.mut_data = 8'h00;
    endtask

    task automatic wait_done_a();
        for (int i = 0; i < 20 && !ifa.done; i++) tick();
        n_vec++;
        if (ifa.done !== 1'b1) begin
            n_err++;
            $display("FAIL wait_done_a timeout done=%b exp 1", ifa.done);
        end
    endtask

    task automatic wait_done_b();
        for (int i = 0; i < 20 && !ifb.done; i++) tick();
        n_vec++;
        if (ifb.done !== 1'b1) begin
            n_err++;
            $display("FAIL wait_done_b timeout done=%b exp 1", ifb.done);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        n_vec++;
        if ({ifa.busy, ifa.done, ifa.pass, ifa.fail, ifa.ff_vld} !== 5'b0 ||
            ifa.fail_cnt !== 8'h00 || ifa.ff_addr !== 8'h00 ||
            ifa.ff_data !== 8'h00 || ifa.ff_exp !== 8'h00) begin
            n_err++;
            $display("FAIL %s outputs busy=%b done=%b pass=%b fail=%b cnt=%0h ffv=%b ffa=%0h ffd=%0h ffe=%0h exp all 0",
                     tag, ifa.busy, ifa.done, ifa.pass, ifa.fail, ifa.fail_cnt, ifa.ff_vld,
                     ifa.ff_addr, ifa.ff_data, ifa.ff_exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        check_idle_zero("reset_held");
        rst = 1'b0;
        tick();
        check_idle_zero("after_reset");
        // reads and test_end in IDLE must be ignored
        ifa.test_end = 1'b1;
        rd_a(8'h01, 8'hFF, 8'hFF, 8'h00);
        ifa.test_end = 1'b0;
        check_idle_zero("idle_ignores_rd");
    endtask

    task automatic test_all_pass();
        start_a();
        n_vec++;
        if (ifa.busy !== 1'b1) begin
            n_err++;
            $display("FAIL pass_busy got %b exp 1", ifa.busy);
        end
        for (int i = 0; i < 4; i++) rd_a(8'(i), 8'hA5, 8'hFF, 8'hA5);
        end_a();
        wait_done_a();
        n_vec++;
        if (ifa.pass !== 1'b1 || ifa.fail !== 1'b0 || ifa.fail_cnt !== 8'd0 || ifa.ff_vld !== 1'b0) begin
            n_err++;
            $display("FAIL all_pass got pass=%b fail=%b cnt=%0d ffv=%b exp 1 0 0 0",
                     ifa.pass, ifa.fail, ifa.fail_cnt, ifa.ff_vld);
        end
    endtask

    task automatic test_first_fail();
        start_a();
        for (int i = 0; i < 8; i++) begin
            rd_a(8'(i), 8'hFF, 8'hFF, (i == 3 || i == 7) ? 8'h00 : 8'hFF);
            if (i == 3) begin
                n_vec++;
                if (ifa.fail !== 1'b1 || ifa.fail_cnt !== 8'd1) begin
                    n_err++;
                    $display("FAIL ff_first_mism got fail=%b cnt=%0d exp 1 1", ifa.fail, ifa.fail_cnt);
                end
            end
        end
        end_a();
        wait_done_a();
        n_vec++;
        if (ifa.fail_cnt !== 8'd2) begin
            n_err++;
            $display("FAIL ff_cnt got %0d exp 2", ifa.fail_cnt);
        end
        n_vec++;
        if (ifa.ff_vld !== 1'b1 || ifa.ff_addr !== 8'h03 || ifa.ff_data !== 8'h00 || ifa.ff_exp !== 8'hFF) begin
            n_err++;
            $display("FAIL ff_log got vld=%b addr=%0h data=%0h exp=%0h exp 1 03 00 FF",
                     ifa.ff_vld, ifa.ff_addr, ifa.ff_data, ifa.ff_exp);
        end
        n_vec++;
        if (ifa.pass !== 1'b0 || ifa.fail !== 1'b1) begin
            n_err++;
            $display("FAIL ff_verdict got pass=%b fail=%b exp 0 1", ifa.pass, ifa.fail);
        end
    endtask

    task automatic test_restart_and_mask();
        start_a();
        n_vec++;
        if (ifa.fail !== 1'b0 || ifa.fail_cnt !== 8'd0 || ifa.ff_vld !== 1'b0 ||
            ifa.busy !== 1'b1 || ifa.done !== 1'b0) begin
            n_err++;
            $display("FAIL restart_clear got fail=%b cnt=%0d ffv=%b busy=%b done=%b exp 0 0 0 1 0",
                     ifa.fail, ifa.fail_cnt, ifa.ff_vld, ifa.busy, ifa.done);
        end
        rd_a(8'h10, 8'h5A, 8'h0F, 8'hAA);
        n_vec++;
        if (ifa.fail !== 1'b0) begin
            n_err++;
            $display("FAIL mask_dont_care got fail=%b exp 0", ifa.fail);
        end
        rd_a(8'h11, 8'h5A, 8'h00, 8'hA5);
        n_vec++;
        if (ifa.fail !== 1'b0) begin
            n_err++;
            $display("FAIL mask_zero got fail=%b exp 0", ifa.fail);
        end
        ifa.rd_en    = 1'b1;
        ifa.rd_addr  = 8'h12;
        ifa.exp_data = 8'h5A;
        ifa.cmp_mask = 8'h0F;
        tick();
        ifa.rd_en    = 1'b0;
        ifa.mut_data = 8'h5B;
        n_vec++;
        if (ifa.fail !== 1'b0) begin
            n_err++;
            $display("FAIL mask_lat_t1 got fail=%b exp 0", ifa.fail);
        end
        tick();
        n_vec++;
        if (ifa.fail !== 1'b1 || ifa.fail_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL mask_lat_t2 got fail=%b cnt=%0d exp 1 1", ifa.fail, ifa.fail_cnt);
        end
        start_a();
        n_vec++;
        if (ifa.fail !== 1'b1 || ifa.fail_cnt !== 8'd1 || ifa.busy !== 1'b1) begin
            n_err++;
            $display("FAIL start_in_run got fail=%b cnt=%0d busy=%b exp 1 1 1",
                     ifa.fail, ifa.fail_cnt, ifa.busy);
        end
        end_a();
        wait_done_a();
        n_vec++;
        if (ifa.ff_addr !== 8'h12 || ifa.ff_data !== 8'h5B || ifa.ff_exp !== 8'h5A || ifa.pass !== 1'b0) begin
            n_err++;
            $display("FAIL mask_log got addr=%0h data=%0h exp=%0h pass=%b exp 12 5B 5A 0",
                     ifa.ff_addr, ifa.ff_data, ifa.ff_exp, ifa.pass);
        end
    endtask

    task automatic test_sat_lat3();
        ifb.test_start = 1'b1;
        tick();
        ifb.test_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd_b(8'(8'h20 + i), 8'hC3, 8'h3C, 1'b0);
            if (i == 0) begin
                n_vec++;
                if (ifb.fail_cnt !== 2'd1 || ifb.ff_addr !== 8'h20) begin
                    n_err++;
                    $display("FAIL lat3_first got cnt=%0d addr=%0h exp 1 20", ifb.fail_cnt, ifb.ff_addr);
                end
            end
        end
        n_vec++;
        if (ifb.fail_cnt !== 2'd3) begin
            n_err++;
            $display("FAIL sat_cnt got %0d exp 3", ifb.fail_cnt);
        end
        ifb.test_end = 1'b1;
        tick();
        ifb.test_end = 1'b0;
        wait_done_b();
        ifb.test_start = 1'b1;
        tick();
        ifb.test_start = 1'b0;
        rd_b(8'h44, 8'h81, 8'h80, 1'b1);
        n_vec++;
        if (ifb.fail !== 1'b1 || ifb.fail_cnt !== 2'd1 || ifb.busy !== 1'b1 || ifb.done !== 1'b0) begin
            n_err++;
            $display("FAIL rd_with_end got fail=%b cnt=%0d busy=%b done=%b exp 1 1 1 0",
                     ifb.fail, ifb.fail_cnt, ifb.busy, ifb.done);
        end
        wait_done_b();
        n_vec++;
        if (ifb.ff_addr !== 8'h44 || ifb.ff_data !== 8'h80 || ifb.ff_exp !== 8'h81 || ifb.pass !== 1'b0) begin
            n_err++;
            $display("FAIL rd_with_end_log got addr=%0h data=%0h exp=%0h pass=%b exp 44 80 81 0",
                     ifb.ff_addr, ifb.ff_data, ifb.ff_exp, ifb.pass);
        end
    endtask

    task automatic test_reset_mid_run();
        start_a();
        rd_a(8'h55, 8'hF0, 8'hFF, 8'h0F);
        n_vec++;
        if (ifa.fail !== 1'b1) begin
            n_err++;
            $display("FAIL pre_rst_fail got %b exp 1", ifa.fail);
        end
        rst = 1'b1;
        tick();
        check_idle_zero("rst_mid_run");
        rst = 1'b0;
        tick();
        check_idle_zero("rst_stays_idle");
        start_a();
        rd_a(8'h56, 8'h3C, 8'hFF, 8'h3C);
        end_a();
        wait_done_a();
        n_vec++;
        if (ifa.pass !== 1'b1 || ifa.fail_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL post_rst_pass got pass=%b cnt=%0d exp 1 0", ifa.pass, ifa.fail_cnt);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        ifa.test_start = 1'b0; ifa.test_end = 1'b0; ifa.rd_en = 1'b0;
        ifa.rd_addr = 8'h00; ifa.exp_data = 8'h00; ifa.cmp_mask = 8'h00; ifa.mut_data = 8'h00;
        ifb.test_start = 1'b0; ifb.test_end = 1'b0; ifb.rd_en = 1'b0;
        ifb.rd_addr = 8'h00; ifb.exp_data = 8'h00; ifb.cmp_mask = 8'h00; ifb.mut_data = 8'h00;
        test_reset();
        test_all_pass();
        test_first_fail();
        test_restart_and_mask();
        test_sat_lat3();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
